window_gen: RTL and testbench

Builds DIM×DIM pixel neighbourhoods ("chunks") from a raster-order single-pixel stream, buffering DIM-1 full image lines. Sits directly upstream of the convolution stage. It feeds that stage's chunk-carrying axis_if slave port, whose output replaces the centre pixel. Only windows lying entirely inside the frame are emitted (valid-region convolution), so each frame yields (WIDTH-DIM+1)×(HEIGHT-DIM+1) chunks.

---
 rtl/pixel_pkg.sv | 11 +
 rtl/axis_if.sv | 24 ++
 rtl/line_buf.sv | 27 ++
 rtl/window_gen.sv | 120 ++++++++++++
 tb/tb_window_gen.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel type for the video pipeline.
// One RGB pixel, 8 bits per channel.
package pixel_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } pixel_t;

endpackage

// File: rtl/axis_if.sv
// Valid/ready channel carrying a DIM x DIM pixel chunk.
// Row index 0 is the oldest line, column index 0 the leftmost pixel.
interface axis_if #(
    parameter int DIM = 3
);
    import pixel_pkg::*;

    logic                           vld;
    logic                           rdy;
    pixel_t [DIM-1:0][DIM-1:0]      data;

    modport master (
        output vld,
        output data,
        input  rdy
    );

    modport slave (
        input  vld,
        input  data,
        output rdy
    );

endinterface

// File: rtl/line_buf.sv
// One image line of storage with read-before-write at a shared address.
// Contents are deliberately not reset.
module line_buf
    import pixel_pkg::*;
#(
    parameter int  DEPTH = 640,
    parameter type T     = pixel_t,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  T              wdata,
    output T              rdata
);

    T mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Builds DIM x DIM neighbourhoods from a raster pixel stream,
// emitting only windows that lie fully inside the frame.
module window_gen
    import pixel_pkg::*;
#(
    parameter int DIM    = 3,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic   clk,
    input  logic   rst,
    input  pixel_t pix_data,
    input  logic   pix_sof,
    input  logic   pix_vld,
    output logic   pix_rdy,
    axis_if.master axis_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(DIM - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(DIM - 1);

    logic [CW-1:0] col, col_nxt, pos_col;
    logic [RW-1:0] row, row_nxt, pos_row;

    logic accept;
    logic emit;

    pixel_t [DIM-1:0][DIM-1:0] win, win_nxt;
    pixel_t [DIM-1:0][DIM-1:0] out_data;
    logic                      out_vld;

    pixel_t lb_rd [DIM-1];
    pixel_t lb_wr [DIM-1];

    assign pix_rdy = !out_vld | axis_o.rdy;
    assign accept  = pix_vld & pix_rdy;

    // A start-of-frame pixel always lands at (0,0), whatever the counters say.
    assign pos_col = pix_sof ? '0 : col;
    assign pos_row = pix_sof ? '0 : row;

    assign emit = accept
                & (pos_row >= ROW_MIN)
                & (pos_col >= COL_MIN);

    always_comb begin
        col_nxt = pos_col + CW'(1);
        row_nxt = pos_row;
        if (pos_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
        end
    end

    for (genvar k = 0; k < DIM - 1; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_wr[k] = pix_data;
        end else begin : g_tail
            assign lb_wr[k] = lb_rd[k-1];
        end

        line_buf #(
            .DEPTH (WIDTH),
            .T     (pixel_t)
        ) u_lb (
            .clk   (clk),
            .addr  (pos_col),
            .we    (accept),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end

    // Shift left; the new right column is the vertical slice at pos_col.
    always_comb begin
        win_nxt = win;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM - 1; j++) begin
                win_nxt[i][j] = win[i][j+1];
            end
        end
        win_nxt[DIM-1][DIM-1] = pix_data;
        for (int k = 0; k < DIM - 1; k++) begin
            win_nxt[DIM-2-k][DIM-1] = lb_rd[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
            win <= '0;
        end else if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
            win <= win_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (emit) begin
            out_vld  <= 1'b1;
            out_data <= win_nxt;
        end else if (axis_o.rdy) begin
            out_vld  <= 1'b0;
        end
    end

    assign axis_o.vld  = out_vld;
    assign axis_o.data = out_data;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen on a 4x4 frame with 3x3 windows.
// Expected chunks come from a 2-D frame model indexed by raster position.
module tb_window_gen;
    import pixel_pkg::*;

    localparam int D = 3;
    localparam int W = 4;
    localparam int H = 4;

    typedef pixel_t [D-1:0][D-1:0] chunk_t;

    typedef struct {
        int         r;
        int         c;
        logic       sof;
        logic       exp_vld;
        logic [7:0] exp_tl;
    } vec_t;

    logic   clk;
    logic   rst_n;
    pixel_t pix_data;
    logic   pix_sof;
    logic   pix_vld;
    logic   pix_rdy;

    axis_if #(.DIM(D)) axis ();

    window_gen #(
        .DIM    (D),
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .pix_data (pix_data),
        .pix_sof  (pix_sof),
        .pix_vld  (pix_vld),
        .pix_rdy  (pix_rdy),
        .axis_o   (axis)
    );

    int n_vec;
    int n_bad;
    int n_chunks;
    logic rand_rdy;
    logic rand_gap;

    pixel_t fr [H][W];
    chunk_t exp_q [$];

    logic   stall_prev;
    chunk_t held;

    vec_t tbl [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pixel_t mk(int r, int c, logic [7:0] b);
        pixel_t p;
        p.red = 8'(r * 4 + c);
        p.grn = 8'(16 + r * 4 + c);
        p.blu = b;
        return p;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Record the pixel at its frame position; a window is due whenever
    // that position can be the bottom-right corner of a full window.
    task automatic model_accept(int r, int c, pixel_t p);
        chunk_t ch;
        fr[r][c] = p;
        if (r >= D - 1 && c >= D - 1) begin
            for (int i = 0; i < D; i++)
                for (int j = 0; j < D; j++)
                    ch[i][j] = fr[r-(D-1)+i][c-(D-1)+j];
            exp_q.push_back(ch);
        end
    endtask

    task automatic send_pix(int r, int c, logic sof, logic [7:0] b);
        logic acc;
        if (rand_gap) begin
            repeat ($urandom_range(0, 2)) begin
                pix_vld = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        pix_data = mk(r, c, b);
        pix_sof  = sof;
        pix_vld  = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = pix_rdy;
            @(posedge clk);
            #1;
        end
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            model_accept(r, c, mk(r, c, b));
            if (c < D - 1)
                chk($sformatf("wrap_vld_r%0d_c%0d", r, c), 32'(axis.vld), 32'd0);
        end
    endtask

    task automatic send_frame(logic [7:0] b, logic sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(r, c, sof && r == 0 && c == 0, b);
    endtask

    task automatic drain(string nm, int base, int want);
        for (int t = 0; t < 200 && (exp_q.size() != 0 || axis.vld); t++) begin
            @(posedge clk);
            #1;
        end
        chk({nm, "_queue"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_chunks"}, 32'(n_chunks - base), 32'(want));
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            axis.rdy = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", 32'(axis.vld), 32'd1);
                n_vec++;
                if (axis.data !== held) begin
                    n_bad++;
                    $display("FAIL hold_data: got %h want %h", axis.data, held);
                end
            end
            if (axis.vld && !axis.rdy)
                chk("stall_pix_rdy", 32'(pix_rdy), 32'd0);
            if (axis.vld && axis.rdy) begin
                n_chunks++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_chunk: got %h want none", axis.data);
                end else begin
                    if (axis.data !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL chunk: got %h want %h", axis.data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = axis.vld && !axis.rdy;
            held = axis.data;
        end
    end

    initial begin
        int base;
        int k;
        n_vec = 0;
        n_bad = 0;
        n_chunks = 0;
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        stall_prev = 1'b0;
        held = '0;
        rst_n = 1'b0;
        pix_data = '0;
        pix_sof = 1'b0;
        pix_vld = 1'b0;
        axis.rdy = 1'b1;

        k = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                tbl[k] = '{r, c, (r == 0 && c == 0),
                           (r >= 2 && c >= 2), 8'((r - 2) * 4 + (c - 2))};
                k++;
            end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 32'(axis.vld), 32'd0);
        chk("rst_data", 32'(axis.data == '0), 32'd1);
        chk("rst_pix_rdy", 32'(pix_rdy), 32'd1);
        rst_n = 1'b1;

        // Frame 1: table of per-pixel expectations, continuous flow.
        base = n_chunks;
        for (int i = 0; i < 16; i++) begin
            send_pix(tbl[i].r, tbl[i].c, tbl[i].sof, 8'h80);
            chk($sformatf("t%0d_vld", i), 32'(axis.vld), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) begin
                chk($sformatf("t%0d_tl", i), 32'(axis.data[0][0].red),
                    32'(tbl[i].exp_tl));
                chk($sformatf("t%0d_br", i), 32'(axis.data[2][2].red),
                    32'(tbl[i].r * 4 + tbl[i].c));
            end
            if (tbl[i].r == 2 && tbl[i].c == 2)
                for (int a = 0; a < D; a++)
                    for (int b = 0; b < D; b++)
                        chk($sformatf("first_red_%0d%0d", a, b),
                            32'(axis.data[a][b].red), 32'(a * 4 + b));
        end
        drain("frame1", base, 4);

        // Frame 2: downstream stalls for 5 cycles on the first chunk.
        base = n_chunks;
        fork
            send_frame(8'h80, 1'b1);
            begin
                for (int t = 0; t < 200 && !axis.vld; t++) begin
                    @(posedge clk);
                    #1;
                end
                axis.rdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_pix_rdy", 32'(pix_rdy), 32'd0);
                    chk("bp_vld", 32'(axis.vld), 32'd1);
                    @(posedge clk);
                    #1;
                end
                axis.rdy = 1'b1;
            end
        join
        drain("frame2_bp", base, 4);

        // Three back-to-back frames with random source and sink gaps.
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        for (int f = 0; f < 3; f++) begin
            base = n_chunks;
            send_frame(8'h80, 1'b1);
            drain($sformatf("rand_f%0d", f), base, 4);
        end
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        @(posedge clk);
        #1;
        axis.rdy = 1'b1;

        // Partial frame abandoned at (2,3) by a new start of frame.
        base = n_chunks;
        for (int i = 0; i < 11; i++)
            send_pix(i / W, i % W, i == 0, 8'h81);
        send_frame(8'h80, 1'b1);
        drain("sof_resync", base, 5);

        // Reset mid-frame after 9 pixels, then a frame without sof.
        for (int i = 0; i < 9; i++)
            send_pix(i / W, i % W, 1'b0, 8'h80);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(axis.vld), 32'd0);
        chk("midrst_data", 32'(axis.data == '0), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = n_chunks;
        send_frame(8'h80, 1'b0);
        drain("after_rst", base, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
